// File: rtl/demux_pkg.sv
// Shared definitions for the stream demultiplexer: FSM encoding, channel limit
// and the select range check.
package demux_pkg;

  localparam int MAX_CH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOCK = 2'd1,
    DROP = 2'd2
  } state_t;

  function automatic logic sel_in_range(input int sel, input int num_ch);
    return (sel < num_ch) && (sel < MAX_CH);
  endfunction

endpackage

// File: rtl/demux_out_reg.sv
// Single-slot output register holding one beat plus the channel it is destined for.
// A load takes priority over a drain, so a slot can be replaced without a bubble.
module demux_out_reg #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              drain,
  input  logic [SEL_W-1:0]  load_ch,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              vld,
  output logic [SEL_W-1:0]  ch,
  output logic [DATA_W-1:0] data,
  output logic              last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld  <= 1'b0;
      ch   <= '0;
      data <= '0;
      last <= 1'b0;
    end else if (load) begin
      vld  <= 1'b1;
      ch   <= load_ch;
      data <= load_data;
      last <= load_last;
    end else if (drain) begin
      vld <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux_n.sv
// Parametrised 1:N packet stream demultiplexer with a registered output slot.
// The destination is locked on the first beat; out-of-range packets are dropped and counted.
module stream_demux_n
  import demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = $clog2(NUM_CH),
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic [SEL_W-1:0]  s_sel,
  input  logic              s_last,
  output logic [NUM_CH-1:0] m_valid,
  input  logic [NUM_CH-1:0] m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              drop_pulse,
  output logic [CNT_W-1:0]  drop_cnt
);

  state_t             state;
  state_t             state_next;
  logic [SEL_W-1:0]   lock_ch;
  logic [SEL_W-1:0]   load_ch;
  logic [SEL_W-1:0]   out_ch;
  logic               out_vld;
  logic               drain;
  logic               free;
  logic               load;
  logic               drop;
  logic               sel_ok;

  // Only the ready bit of the channel currently holding the slot matters.
  assign drain  = m_ready[out_ch];
  assign free   = !out_vld || drain;
  assign sel_ok = sel_in_range(int'(s_sel), NUM_CH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      lock_ch <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && load) begin
        lock_ch <= s_sel;
      end
    end
  end

  always_comb begin
    state_next = state;
    s_ready    = 1'b0;
    load       = 1'b0;
    drop       = 1'b0;
    load_ch    = s_sel;
    unique case (state)
      IDLE: begin
        if (sel_ok) begin
          s_ready = free;
          load    = s_valid && free;
          if (load && !s_last) begin
            state_next = LOCK;
          end
        end else begin
          s_ready = 1'b1;
          drop    = s_valid;
          if (s_valid && !s_last) begin
            state_next = DROP;
          end
        end
      end
      LOCK: begin
        s_ready = free;
        load    = s_valid && free;
        load_ch = lock_ch;
        if (load && s_last) begin
          state_next = IDLE;
        end
      end
      DROP: begin
        s_ready = 1'b1;
        drop    = s_valid;
        if (s_valid && s_last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  demux_out_reg #(
    .DATA_W (DATA_W),
    .SEL_W  (SEL_W)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .drain     (drain),
    .load_ch   (load_ch),
    .load_data (s_data),
    .load_last (s_last),
    .vld       (out_vld),
    .ch        (out_ch),
    .data      (m_data),
    .last      (m_last)
  );

  always_comb begin
    m_valid = '0;
    if (out_vld) begin
      m_valid[out_ch] = 1'b1;
    end
  end

  // Saturating drop counter; the pulse keeps firing once the count is pinned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_pulse <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      drop_pulse <= drop;
      if (drop && drop_cnt != '1) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stream_demux_n.sv
// Scoreboard bench for stream_demux_n built with five channels (non power of two)
// and a 3-bit drop counter so that routing, dropping and saturation are all reachable.
module tb_stream_demux_n;

  localparam int DATA_W  = 8;
  localparam int NUM_CH  = 5;
  localparam int SEL_W   = $clog2(NUM_CH);
  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] s_data = '0;
  logic [SEL_W-1:0]  s_sel = '0;
  logic              s_last = 1'b0;
  logic [NUM_CH-1:0] m_valid;
  logic [NUM_CH-1:0] m_ready = '1;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              drop_pulse;
  logic [CNT_W-1:0]  drop_cnt;

  typedef struct {
    int                ch;
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  beat_t             exp_q[$];
  int                tests = 0;
  int                fails = 0;
  int                exp_drops = 0;
  bit                exp_pulse = 1'b0;
  bit                in_pkt = 1'b0;
  bit                pkt_drop = 1'b0;
  int                pkt_ch = 0;
  int                ready_mode = 0;
  logic [NUM_CH-1:0] ready_force = '1;

  stream_demux_n #(
    .DATA_W (DATA_W),
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_sel      (s_sel),
    .s_last     (s_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .drop_pulse (drop_pulse),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  // Downstream ready: all ready, random, or a fixed mask chosen by the sequence.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       m_ready = '1;
      1:       m_ready = NUM_CH'($urandom);
      default: m_ready = ready_force;
    endcase
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Issues one beat, waits for the handshake, then records what the stream should do with it.
  task automatic applyStimulus(input int sel, input logic [DATA_W-1:0] data, input logic last);
    bit    acc;
    beat_t b;
    acc     = 1'b0;
    s_valid = 1'b1;
    s_sel   = SEL_W'(sel);
    s_data  = data;
    s_last  = last;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_ready === 1'b1) begin
        acc = 1'b1;
        break;
      end
    end
    if (!acc) begin
      tests++;
      fails++;
      $display("[TB] FAIL accept_timeout: beat sel=%0d data=%0h never accepted", sel, data);
      s_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (!in_pkt) begin
      pkt_drop = (sel >= NUM_CH);
      pkt_ch   = sel;
    end
    if (pkt_drop) begin
      exp_drops++;
      exp_pulse = 1'b1;
    end else begin
      b.ch   = pkt_ch;
      b.data = data;
      b.last = last;
      exp_q.push_back(b);
    end
    in_pkt = !last;
    #1 s_valid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clearModel();
    exp_q.delete();
    in_pkt    = 1'b0;
    pkt_drop  = 1'b0;
    exp_drops = 0;
    exp_pulse = 1'b0;
  endtask

  // Monitor: compares the presented slot with the scoreboard head every cycle.
  always @(negedge clk) begin
    logic [NUM_CH-1:0] ev;
    bit                drop_now;
    bit                exp_rdy;
    int                exp_cnt;
    if (!rst) begin
      ev = '0;
      if (exp_q.size() > 0) ev[exp_q[0].ch] = 1'b1;
      checkOutput("m_valid", m_valid, ev);
      if (exp_q.size() > 0) begin
        checkOutput("m_data", m_data, exp_q[0].data);
        checkOutput("m_last", m_last, exp_q[0].last);
      end
      drop_now = in_pkt ? pkt_drop : (int'(s_sel) >= NUM_CH);
      exp_rdy  = drop_now || (exp_q.size() == 0) || m_ready[exp_q[0].ch];
      checkOutput("s_ready", s_ready, exp_rdy);
      checkOutput("drop_pulse", drop_pulse, exp_pulse);
      exp_pulse = 1'b0;
      exp_cnt = (exp_drops > CNT_MAX) ? CNT_MAX : exp_drops;
      checkOutput("drop_cnt", drop_cnt, exp_cnt);
      if (exp_q.size() > 0 && m_ready[exp_q[0].ch]) void'(exp_q.pop_front());
    end
  end

  initial begin
    int len;
    int first_sel;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_m_valid", m_valid, 0);
    checkOutput("reset_m_data", m_data, 0);
    checkOutput("reset_m_last", m_last, 0);
    checkOutput("reset_drop_pulse", drop_pulse, 0);
    checkOutput("reset_drop_cnt", drop_cnt, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    idleCycles(1);

    // Single-beat packets to every channel, back to back.
    for (int s = 0; s < NUM_CH; s++) applyStimulus(s, 8'hA0 + DATA_W'(s), 1'b1);
    idleCycles(3);

    // Channel locked on the first beat even though later selects differ.
    applyStimulus(2, 8'hB0, 1'b0);
    applyStimulus(1, 8'hB1, 1'b0);
    applyStimulus(4, 8'hB2, 1'b0);
    applyStimulus(1, 8'hB3, 1'b1);
    applyStimulus(1, 8'hB4, 1'b1);
    idleCycles(3);

    // Back-pressure on channel 1 while other channels stay ready.
    ready_mode  = 2;
    ready_force = 5'b11101;
    idleCycles(2);
    applyStimulus(1, 8'h51, 1'b0);
    fork
      applyStimulus(1, 8'h52, 1'b1);
      begin
        repeat (5) begin
          @(negedge clk);
          checkOutput("bp_s_ready", s_ready, 0);
          checkOutput("bp_m_data", m_data, 8'h51);
          checkOutput("bp_m_valid", m_valid, 5'b00010);
        end
        ready_force = '1;
      end
    join
    applyStimulus(3, 8'h53, 1'b1);
    ready_mode = 0;
    idleCycles(3);

    // Dropped 3-beat packet, then a normal packet, then drops past saturation.
    applyStimulus(6, 8'hC0, 1'b0);
    applyStimulus(0, 8'hC1, 1'b0);
    applyStimulus(2, 8'hC2, 1'b1);
    applyStimulus(0, 8'hC3, 1'b1);
    for (int k = 0; k < 6; k++) applyStimulus((k % 2) ? 7 : 5, 8'hE0 + DATA_W'(k), 1'b1);
    idleCycles(2);
    checkOutput("drop_cnt_saturated", drop_cnt, CNT_MAX);

    // Reset in the middle of a packet with a beat held in the slot.
    ready_mode  = 2;
    ready_force = '0;
    idleCycles(2);
    applyStimulus(2, 8'hD0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    clearModel();
    #1;
    checkOutput("rst_async_m_valid", m_valid, 0);
    checkOutput("rst_async_drop_cnt", drop_cnt, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    ready_mode = 0;
    idleCycles(1);
    applyStimulus(1, 8'hD1, 1'b1);
    idleCycles(3);

    // Randomised packets against random downstream readiness.
    ready_mode = 1;
    for (int p = 0; p < 80; p++) begin
      len       = $urandom_range(1, 4);
      first_sel = $urandom_range(0, (1 << SEL_W) - 1);
      for (int b = 0; b < len; b++) begin
        applyStimulus((b == 0) ? first_sel : $urandom_range(0, (1 << SEL_W) - 1),
                      DATA_W'($urandom), b == len - 1);
        if ($urandom_range(0, 3) == 0) idleCycles(1);
      end
    end

    ready_mode = 0;
    idleCycles(6);
    checkOutput("drain_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stream_demux_n.md
Name: stream_demux_n

Overview:
- Parametrised 1:N stream demultiplexer; successor to the fixed 1:4 combinational demux.
- Routes a valid/ready packet stream to one of NUM_CH output channels, with a registered output stage.
- Output channel is locked per packet: sampled on the first beat, held until the last beat.
- Beats with an out-of-range select are accepted and dropped; drops are reported and counted.

Parameters:
- DATA_W, 8, payload width in bits.
- NUM_CH, 4, number of output channels (2..16; need not be a power of two).
- SEL_W, $clog2(NUM_CH), select width (derived; do not override).
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid && s_ready.
- s_data  in  DATA_W  input payload.
- s_sel  in  SEL_W  destination channel; sampled only on the first beat of a packet.
- s_last  in  1  marks the final beat of a packet.
- m_valid  out  NUM_CH  per-channel valid; at most one bit set (one-hot or zero).
- m_ready  in  NUM_CH  per-channel ready.
- m_data  out  DATA_W  shared output payload, meaningful only for the channel whose m_valid is set.
- m_last  out  1  last flag of the presented beat.
- drop_pulse  out  1  one-cycle pulse for each dropped beat.
- drop_cnt  out  CNT_W  count of dropped beats; saturates at all-ones.

Behaviour:
- Reset (async assert, sync release): m_valid=0, m_data=0, m_last=0, drop_pulse=0, drop_cnt=0, state=IDLE, lock_ch=0. Reset mid-packet discards the held beat and the lock; the next accepted beat is treated as a first beat.
- Output register: one slot holding {out_ch, data, last}; out_vld=|m_valid. m_valid[out_ch]=out_vld.
- Slot free: free = !out_vld || m_ready[out_ch]. m_ready bits of other channels are ignored.
- Latency: an accepted beat appears on m_* on the next cycle. Full throughput (1 beat/cycle) while the destination stays ready.
- FSM states:
  - IDLE: waiting for the first beat of a packet.
  - LOCK: inside a routed packet; lock_ch holds the channel.
  - DROP: inside a packet being discarded.
- IDLE, s_sel < NUM_CH:
  - s_ready=free.
  - On accept: load the slot with ch=s_sel; lock_ch<=s_sel.
  - Go to LOCK if !s_last; stay in IDLE if s_last (single-beat packet).
- IDLE, s_sel >= NUM_CH:
  - s_ready=1.
  - On accept: no slot load; drop_pulse=1; drop_cnt+1.
  - Go to DROP if !s_last.
- LOCK:
  - s_ready=free; s_sel is ignored.
  - On accept: load the slot with ch=lock_ch.
  - An accepted s_last returns to IDLE.
- DROP:
  - s_ready=1; every accepted beat pulses drop_pulse and increments drop_cnt.
  - An accepted s_last returns to IDLE.
- Simultaneous drain and load (out_vld && m_ready[out_ch] && accept): the slot is replaced in the same cycle, m_valid stays high with no bubble, and the channel may change across a packet boundary.
- Drain with no accept: m_valid<=0. m_data and m_last hold their last value (not cleared).
- Back-pressure: while the slot is full and the destination is not ready, all of m_* stay stable. The source observes s_ready=0 (IDLE-valid and LOCK states).
- drop_cnt: at all-ones, further drops still pulse drop_pulse but the counter stays at its maximum.
- Invariant: m_valid is never multi-hot.

Decomposition:
- Shared package demux_pkg holds:
  - state encoding typedef: IDLE=2'd0, LOCK=2'd1, DROP=2'd2;
  - a function for the select range check;
  - the constant for the maximum supported NUM_CH (16).
- One sub-module is natural: demux_out_reg (single-slot register with load/drain and channel tag).
- The FSM, drop counter and one-hot decode stay in the top level.

Test Plan:
- Single-beat packets, sel=0,1,2,3 in turn, data 8'hA0..A3, last=1, all m_ready=1 -> each appears one cycle later on m_valid = 4'b0001, 4'b0010, 4'b0100, 4'b1000 with the matching data; s_ready stays 1.
- Packet of 4 beats, sel=2 on beat 0 and sel changed to 1 on beats 1-3 -> all 4 beats reach channel 2; FSM returns to IDLE after the last beat.
- Back-pressure: m_ready[1]=0 for 5 cycles with a beat held for channel 1, other channels ready -> s_ready=0 and m_data stable for all 5 cycles; after release, next beat has no bubble.
- NUM_CH=3 build, 3-beat packet with sel=3 -> s_ready=1, three drop_pulse cycles, drop_cnt=3, m_valid never set; the following sel=0 packet routes normally.
- CNT_W=2, 5 dropped beats -> drop_cnt sequence 1, 2, 3, 3, 3; drop_pulse still asserted on beats 4 and 5.
- rst asserted mid-packet with a beat held (m_valid=4'b0100) -> m_valid=0 asynchronously; after release, a beat with sel=1 routes to channel 1, which proves the lock was cleared.
